// File: rtl/seq_datapath_pkg.sv
// Shared types for the self-sequencing datapath: ALU/shift encodings,
// sequencer states, status bit positions and the captured command payload.
package seq_datapath_pkg;

  localparam int unsigned STAT_W = 3;
  localparam int unsigned STAT_N = 2;
  localparam int unsigned STAT_V = 1;
  localparam int unsigned STAT_Z = 0;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADA = 3'd1,
    ST_LOADB = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WB    = 3'd4
  } state_t;

  // Operation fields latched when a request is accepted.
  typedef struct packed {
    alu_op_t alu_op;
    shift_t  shift;
    logic    bsel;
  } ctrl_t;

endpackage

// File: rtl/seq_datapath_if.sv
// Request/status bundle between controller (master) and datapath (slave).
//  start/alu_op/shift/mov_imm/bsel/rn/rm/rd/imm : operation request
//  ext_we/ext_addr/ext_data                     : external register write
//  dbg_addr -> dbg_data                         : combinational register peek
//  busy/done/result/status                      : sequencer outputs
interface seq_datapath_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8
);
  localparam int unsigned AW = $clog2(NREGS);

  logic             start;
  logic [1:0]       alu_op;
  logic [1:0]       shift;
  logic             mov_imm;
  logic             bsel;
  logic [AW-1:0]    rn;
  logic [AW-1:0]    rm;
  logic [AW-1:0]    rd;
  logic [WIDTH-1:0] imm;
  logic             ext_we;
  logic [AW-1:0]    ext_addr;
  logic [WIDTH-1:0] ext_data;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [2:0]       status;

  modport master (
    output start, alu_op, shift, mov_imm, bsel, rn, rm, rd, imm,
           ext_we, ext_addr, ext_data, dbg_addr,
    input  dbg_data, busy, done, result, status
  );

  modport slave (
    input  start, alu_op, shift, mov_imm, bsel, rn, rm, rd, imm,
           ext_we, ext_addr, ext_data, dbg_addr,
    output dbg_data, busy, done, result, status
  );
endinterface

// File: rtl/alu_shift_unit.sv
// Combinational shifter + ALU + {N,V,Z} flag generation.
//  a_i, b_i  : operands (b_i is shifted before the ALU)
//  alu_op_i  : ADD / SUB / AND / NOT(B)
//  shift_i   : none / LSL1 / LSR1 / ASR1
//  y_c       : result, modulo 2^WIDTH
//  status_c  : {N,V,Z}
module alu_shift_unit
  import seq_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  alu_op_t           alu_op_i,
  input  shift_t            shift_i,
  output logic [WIDTH-1:0]  y_c,
  output logic [STAT_W-1:0] status_c
);

  logic [WIDTH-1:0] bs;
  logic             v;

  // Shifter on the B operand.
  always_comb begin
    bs = b_i;
    case (shift_i)
      SH_NONE: bs = b_i;
      SH_LSL1: bs = {b_i[WIDTH-2:0], 1'b0};
      SH_LSR1: bs = {1'b0, b_i[WIDTH-1:1]};
      SH_ASR1: bs = {b_i[WIDTH-1], b_i[WIDTH-1:1]};
      default: bs = b_i;
    endcase
  end

  // ALU and flags; overflow only meaningful for ADD/SUB.
  always_comb begin
    y_c      = '0;
    v        = 1'b0;
    status_c = '0;
    case (alu_op_i)
      ALU_ADD: begin
        y_c = a_i + bs;
        v   = (a_i[WIDTH-1] == bs[WIDTH-1]) && (y_c[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_SUB: begin
        y_c = a_i - bs;
        v   = (a_i[WIDTH-1] != bs[WIDTH-1]) && (y_c[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_AND: y_c = a_i & bs;
      ALU_NOT: y_c = ~bs;
      default: y_c = '0;
    endcase
    status_c[STAT_N] = y_c[WIDTH-1];
    status_c[STAT_V] = v;
    status_c[STAT_Z] = (y_c == '0);
  end

endmodule

// File: rtl/seq_datapath.sv
// Self-sequencing datapath: register file, A/B/C registers and status,
// driven by an internal IDLE->LOADA->LOADB->EXEC->WB sequencer.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : seq_datapath_if slave (request, external write, debug peek,
//               busy/done/result/status)
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_datapath_if.slave  bus
);

  localparam int unsigned AW = $clog2(NREGS);

  state_t              state_q,  state_d;
  logic                busy_q,   busy_d;
  logic                done_q,   done_d;
  logic [WIDTH-1:0]    a_q,      a_d;
  logic [WIDTH-1:0]    b_q,      b_d;
  logic [WIDTH-1:0]    c_q,      c_d;
  logic [STAT_W-1:0]   status_q, status_d;
  ctrl_t               ctrl_q,   ctrl_d;
  logic [AW-1:0]       rn_q,     rn_d;
  logic [AW-1:0]       rm_q,     rm_d;
  logic [AW-1:0]       rd_q,     rd_d;
  logic [WIDTH-1:0]    imm_q,    imm_d;
  logic [WIDTH-1:0]    regs_q [NREGS];
  logic [WIDTH-1:0]    regs_d [NREGS];

  logic [WIDTH-1:0]    alu_y;
  logic [STAT_W-1:0]   alu_status;

  alu_shift_unit #(.WIDTH(WIDTH)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .alu_op_i (ctrl_q.alu_op),
    .shift_i  (ctrl_q.shift),
    .y_c      (alu_y),
    .status_c (alu_status)
  );

  // Sequencer next state, holding-register capture and register-file writes.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    status_d = status_q;
    ctrl_d   = ctrl_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    regs_d   = regs_q;

    // External write first so a same-index write-back below overrides it.
    if (bus.ext_we) begin
      regs_d[bus.ext_addr] = bus.ext_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          ctrl_d = '{alu_op: alu_op_t'(bus.alu_op),
                     shift:  shift_t'(bus.shift),
                     bsel:   bus.bsel};
          rn_d   = bus.rn;
          rm_d   = bus.rm;
          rd_d   = bus.rd;
          imm_d  = bus.imm;
          if (bus.mov_imm) begin
            c_d     = bus.imm;
            state_d = ST_WB;
          end else begin
            state_d = ST_LOADA;
          end
        end
      end
      ST_LOADA: begin
        a_d = regs_q[rn_q];
        // With bsel the immediate takes B's place and LOADB is skipped.
        if (ctrl_q.bsel) begin
          b_d     = imm_q;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_LOADB;
        end
      end
      ST_LOADB: begin
        b_d     = regs_q[rm_q];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        c_d      = alu_y;
        status_d = alu_status;
        state_d  = ST_WB;
      end
      ST_WB: begin
        regs_d[rd_q] = c_q;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
      ctrl_q   <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      regs_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      status_q <= status_d;
      ctrl_q   <= ctrl_d;
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      regs_q   <= regs_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = c_q;
  assign bus.status   = status_q;
  // Debug peek sees only the registered contents, not same-edge writes.
  assign bus.dbg_data = regs_q[bus.dbg_addr];

endmodule

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath: table of ALU vectors on a 16-bit/8-reg
// instance, hand-written multi-cycle sequences, and an 8-bit/4-reg instance.
module tb_seq_datapath;
  import seq_datapath_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  seq_datapath_if #(.WIDTH(16), .NREGS(8)) bus16 ();
  seq_datapath_if #(.WIDTH(8),  .NREGS(4)) bus8 ();

  seq_datapath #(.WIDTH(16), .NREGS(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  seq_datapath #(.WIDTH(8),  .NREGS(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [15:0] ra;
    logic [15:0] rb;
    logic [1:0]  op;
    logic [1:0]  sh;
    logic        bsel;
    logic [15:0] imm;
    logic [15:0] exp_res;
    logic [2:0]  exp_st;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_write16(input logic [2:0] a, input logic [15:0] d);
    bus16.ext_we   = 1'b1;
    bus16.ext_addr = a;
    bus16.ext_data = d;
    tick();
    bus16.ext_we   = 1'b0;
  endtask

  task automatic set_op16(input logic [1:0] op, input logic [1:0] sh, input logic bsel,
                          input logic mov, input logic [2:0] rn, input logic [2:0] rm,
                          input logic [2:0] rd, input logic [15:0] imm);
    bus16.alu_op  = op;
    bus16.shift   = sh;
    bus16.bsel    = bsel;
    bus16.mov_imm = mov;
    bus16.rn      = rn;
    bus16.rm      = rm;
    bus16.rd      = rd;
    bus16.imm     = imm;
  endtask

  task automatic start16();
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
  endtask

  task automatic wait_done16(output int lat);
    lat = 0;
    while (bus16.done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic read16(input logic [2:0] a, output logic [15:0] d);
    bus16.dbg_addr = a;
    #1;
    d = bus16.dbg_data;
  endtask

  initial begin
    int          lat;
    int          pulses;
    logic [15:0] rv;

    vecs[0]  = '{16'h0007, 16'h0002, 2'b00, 2'b01, 1'b0, 16'h0000, 16'h000B, 3'b000};
    vecs[1]  = '{16'h7FFF, 16'h0001, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h8000, 3'b110};
    vecs[2]  = '{16'h0001, 16'h0001, 2'b01, 2'b00, 1'b0, 16'h0000, 16'h0000, 3'b001};
    vecs[3]  = '{16'h0000, 16'h800F, 2'b00, 2'b11, 1'b0, 16'h0000, 16'hC007, 3'b100};
    vecs[4]  = '{16'h0007, 16'h0002, 2'b11, 2'b00, 1'b0, 16'h0000, 16'hFFFD, 3'b100};
    vecs[5]  = '{16'h8000, 16'h0001, 2'b01, 2'b00, 1'b0, 16'h0000, 16'h7FFF, 3'b010};
    vecs[6]  = '{16'hF0F0, 16'h3C3C, 2'b10, 2'b00, 1'b0, 16'h0000, 16'h3030, 3'b000};
    vecs[7]  = '{16'h1234, 16'h0000, 2'b00, 2'b00, 1'b1, 16'hFFFF, 16'h1233, 3'b000};
    vecs[8]  = '{16'h4000, 16'h0002, 2'b00, 2'b10, 1'b0, 16'h0000, 16'h4001, 3'b000};
    vecs[9]  = '{16'h0000, 16'h8000, 2'b01, 2'b01, 1'b0, 16'h0000, 16'h0000, 3'b001};
    vecs[10] = '{16'h0005, 16'h0000, 2'b01, 2'b01, 1'b1, 16'h0002, 16'h0001, 3'b000};
    vecs[11] = '{16'h8000, 16'h8000, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 3'b011};
    vecs[12] = '{16'h0001, 16'h0000, 2'b11, 2'b11, 1'b1, 16'h8001, 16'h3FFF, 3'b000};

    rst_n = 1'b1;
    bus16.start = 1'b0; bus16.ext_we = 1'b0; bus16.ext_addr = '0; bus16.ext_data = '0;
    bus16.dbg_addr = '0;
    set_op16(2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0);
    bus8.start = 1'b0; bus8.alu_op = '0; bus8.shift = '0; bus8.mov_imm = 1'b0;
    bus8.bsel = 1'b0; bus8.rn = '0; bus8.rm = '0; bus8.rd = '0; bus8.imm = '0;
    bus8.ext_we = 1'b0; bus8.ext_addr = '0; bus8.ext_data = '0; bus8.dbg_addr = '0;

    // Reset state
    #3 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy",   32'(bus16.busy),   32'd0);
    chk("rst_done",   32'(bus16.done),   32'd0);
    chk("rst_result", 32'(bus16.result), 32'd0);
    chk("rst_status", 32'(bus16.status), 32'd0);
    for (int r = 0; r < 8; r++) begin
      read16(3'(r), rv);
      chk($sformatf("rst_r%0d", r), 32'(rv), 32'd0);
    end
    chk("rst8_busy", 32'(bus8.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven ALU vectors: rd=2, rn=0, rm=1
    for (int i = 0; i < 13; i++) begin
      ext_write16(3'd0, vecs[i].ra);
      ext_write16(3'd1, vecs[i].rb);
      set_op16(vecs[i].op, vecs[i].sh, vecs[i].bsel, 1'b0, 3'd0, 3'd1, 3'd2, vecs[i].imm);
      start16();
      chk($sformatf("v%0d_busy", i), 32'(bus16.busy), 32'd1);
      wait_done16(lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), vecs[i].bsel ? 32'd3 : 32'd4);
      chk($sformatf("v%0d_busy_done", i), 32'(bus16.busy), 32'd0);
      chk($sformatf("v%0d_res", i), 32'(bus16.result), 32'(vecs[i].exp_res));
      chk($sformatf("v%0d_st", i), 32'(bus16.status), 32'(vecs[i].exp_st));
      read16(3'd2, rv);
      chk($sformatf("v%0d_r2", i), 32'(rv), 32'(vecs[i].exp_res));
      tick();
      chk($sformatf("v%0d_done_pulse", i), 32'(bus16.done), 32'd0);
    end

    // mov_imm: status preserved from prior SUB, one-edge latency
    ext_write16(3'd0, 16'h0001);
    ext_write16(3'd1, 16'h0001);
    set_op16(2'b01, 2'b00, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 16'h0);
    start16();
    wait_done16(lat);
    chk("sub_st", 32'(bus16.status), 32'b001);
    tick();
    set_op16(2'b00, 2'b00, 1'b0, 1'b1, 3'd0, 3'd0, 3'd3, 16'h0005);
    start16();
    wait_done16(lat);
    chk("mov_lat",    32'(lat),           32'd1);
    chk("mov_result", 32'(bus16.result),  32'h5);
    chk("mov_status", 32'(bus16.status),  32'b001);
    read16(3'd3, rv);
    chk("mov_r3", 32'(rv), 32'h5);
    tick();

    // start pulsed during LOADB is ignored; captured rd survives caller changes
    ext_write16(3'd0, 16'h0007);
    ext_write16(3'd1, 16'h0002);
    set_op16(2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 3'd1, 3'd4, 16'h0);
    start16();
    tick();
    bus16.rd = 3'd6;
    start16();
    wait_done16(lat);
    chk("ign_lat", 32'(lat), 32'd2);
    read16(3'd4, rv);
    chk("ign_r4", 32'(rv), 32'h9);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus16.done === 1'b1) pulses++;
    end
    chk("ign_pulses", 32'(pulses), 32'd0);
    read16(3'd6, rv);
    chk("ign_r6", 32'(rv), 32'h0);

    // start in the done cycle is accepted
    set_op16(2'b01, 2'b00, 1'b0, 1'b0, 3'd0, 3'd1, 3'd3, 16'h0);
    start16();
    wait_done16(lat);
    chk("b2b_lat1", 32'(lat), 32'd4);
    set_op16(2'b00, 2'b00, 1'b1, 1'b0, 3'd0, 3'd1, 3'd5, 16'h0010);
    start16();
    read16(3'd3, rv);
    chk("b2b_r3", 32'(rv), 32'h5);
    chk("b2b_busy", 32'(bus16.busy), 32'd1);
    wait_done16(lat);
    chk("b2b_lat2", 32'(lat), 32'd3);
    chk("b2b_res", 32'(bus16.result), 32'h17);
    read16(3'd5, rv);
    chk("b2b_r5", 32'(rv), 32'h17);
    tick();

    // ext_we to rd on the WB edge: write-back wins
    set_op16(2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 16'h0);
    start16();
    tick(); tick(); tick();
    bus16.ext_we = 1'b1; bus16.ext_addr = 3'd2; bus16.ext_data = 16'hDEAD;
    tick();
    bus16.ext_we = 1'b0;
    chk("coll_done", 32'(bus16.done), 32'd1);
    read16(3'd2, rv);
    chk("coll_r2", 32'(rv), 32'h9);
    tick();

    // ext_we to another index on the WB edge: both land
    set_op16(2'b01, 2'b00, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 16'h0);
    start16();
    tick(); tick(); tick();
    bus16.ext_we = 1'b1; bus16.ext_addr = 3'd7; bus16.ext_data = 16'h1234;
    tick();
    bus16.ext_we = 1'b0;
    read16(3'd2, rv);
    chk("both_r2", 32'(rv), 32'h5);
    read16(3'd7, rv);
    chk("both_r7", 32'(rv), 32'h1234);
    tick();

    // ext_we to rn on the accepting edge: LOADA sees the new value
    set_op16(2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 16'h0);
    bus16.ext_we = 1'b1; bus16.ext_addr = 3'd0; bus16.ext_data = 16'h0100;
    start16();
    bus16.ext_we = 1'b0;
    wait_done16(lat);
    chk("raw_res", 32'(bus16.result), 32'h0102);
    tick();

    // Reset during EXEC aborts with no write-back
    set_op16(2'b00, 2'b01, 1'b0, 1'b0, 3'd0, 3'd1, 3'd6, 16'h0);
    start16();
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy",   32'(bus16.busy),   32'd0);
    chk("mid_done",   32'(bus16.done),   32'd0);
    chk("mid_result", 32'(bus16.result), 32'd0);
    chk("mid_status", 32'(bus16.status), 32'd0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus16.done === 1'b1) pulses++;
    end
    chk("mid_pulses", 32'(pulses), 32'd0);
    for (int r = 0; r < 8; r++) begin
      read16(3'(r), rv);
      chk($sformatf("mid_r%0d", r), 32'(rv), 32'd0);
    end
    tick();

    // 8-bit instance: 8'h7F + 1
    bus8.ext_we = 1'b1; bus8.ext_addr = 2'd0; bus8.ext_data = 8'h7F;
    tick();
    bus8.ext_addr = 2'd1; bus8.ext_data = 8'h01;
    tick();
    bus8.ext_we = 1'b0;
    bus8.alu_op = 2'b00; bus8.shift = 2'b00; bus8.rn = 2'd0; bus8.rm = 2'd1; bus8.rd = 2'd2;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("w8_lat",    32'(lat),          32'd4);
    chk("w8_result", 32'(bus8.result),  32'h80);
    chk("w8_status", 32'(bus8.status),  32'b110);
    bus8.dbg_addr = 2'd2;
    #1;
    chk("w8_r2", 32'(bus8.dbg_data), 32'h80);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
